// File: rtl/sa_pkg.sv
// Shared types and constants for the systolic-array sequencer.
package sa_pkg;

    localparam int SA_D_W  = 16;
    localparam int SA_ROWS = 16;
    localparam int SA_COLS = 16;
    localparam int SA_K_W  = 10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_PRIME = 3'd2,
        S_FEED  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Extra steps after the last operand so element K-1 crosses to the far corner PE.
    function automatic int drain_len(input int rows, input int cols);
        return rows + cols - 2;
    endfunction

    localparam int SA_DRAIN = SA_ROWS + SA_COLS - 2;

endpackage

// File: rtl/sa_skew.sv
// Diagonal skew buffer: lane i is a shift chain of depth i+1, all lanes advance together.
module sa_skew #(
    parameter int LANES = 16,
    parameter int D_W   = 16
) (
    input  logic                 I_CLK,
    input  logic                 I_ASYN_RST,
    input  logic                 I_LOAD,
    input  logic                 I_CLEAR,
    input  logic [LANES*D_W-1:0] I_HEAD,
    output logic [LANES*D_W-1:0] O_TAIL
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [D_W-1:0] chain [0:i];

        always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
            if (I_ASYN_RST) begin
                for (int d = 0; d <= i; d++) chain[d] <= '0;
            end else if (I_CLEAR) begin
                for (int d = 0; d <= i; d++) chain[d] <= '0;
            end else if (I_LOAD) begin
                chain[0] <= I_HEAD[i*D_W +: D_W];
                for (int d = 1; d <= i; d++) chain[d] <= chain[d-1];
            end
        end

        assign O_TAIL[i*D_W +: D_W] = chain[i];
    end

endmodule

// File: rtl/sa_ctrl.sv
// Job sequencer for the output-stationary systolic array: fetches operands by index,
// skews them onto the array edges in lockstep with the PE-shift pulse, then drains.
module sa_ctrl
    import sa_pkg::*;
#(
    parameter int D_W  = SA_D_W,
    parameter int SA_R = SA_ROWS,
    parameter int SA_C = SA_COLS,
    parameter int K_W  = SA_K_W
) (
    input  logic                I_CLK,
    input  logic                I_ASYN_RST,
    input  logic                I_START,
    input  logic [K_W-1:0]      I_K_LEN,
    output logic                O_BUSY,
    output logic                O_DONE,
    output logic                O_RD_EN,
    output logic [K_W-1:0]      O_RD_IDX,
    input  logic [D_W*SA_R-1:0] I_X_VEC,
    input  logic [D_W*SA_C-1:0] I_W_VEC,
    output logic                O_SA_START,
    output logic                O_SA_SYNC_RSTN,
    output logic [D_W*SA_R-1:0] O_SA_X,
    output logic [D_W*SA_C-1:0] O_SA_W,
    input  logic                I_SA_SHIFT,
    output logic [2:0]          O_DBG_STATE
);

    localparam int CNT_W = K_W + 6;
    localparam logic [CNT_W-1:0] DRAIN = CNT_W'(drain_len(SA_R, SA_C));

    state_t           state, state_nx;
    logic [K_W-1:0]   k_len;
    logic [CNT_W-1:0] k_len_ext;
    logic [CNT_W-1:0] k_cnt;
    logic [CNT_W-1:0] step_cnt;
    logic             load;
    logic             clear;
    logic             head_en;

    assign k_len_ext = CNT_W'(k_len);

    always_ff @(posedge I_CLK or posedge I_ASYN_RST) begin
        if (I_ASYN_RST) begin
            state    <= S_IDLE;
            k_len    <= '0;
            k_cnt    <= '0;
            step_cnt <= '0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (I_START && I_K_LEN != '0) begin
                    k_len    <= I_K_LEN;
                    k_cnt    <= '0;
                    step_cnt <= '0;
                end
                S_PRIME: k_cnt <= CNT_W'(1);
                S_FEED: if (I_SA_SHIFT) begin
                    k_cnt    <= k_cnt + CNT_W'(1);
                    step_cnt <= step_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // A read issued in one cycle is answered on I_X_VEC/I_W_VEC the next cycle and held,
    // so the prefetch of k+1 on a step is always ready by the following step.
    always_comb begin
        state_nx   = state;
        O_RD_EN    = 1'b0;
        O_RD_IDX   = '0;
        O_SA_START = 1'b0;
        load       = 1'b0;
        clear      = 1'b0;
        case (state)
            S_IDLE: if (I_START && I_K_LEN != '0) state_nx = S_CLR;
            S_CLR: begin
                clear    = 1'b1;
                O_RD_EN  = 1'b1;
                state_nx = S_PRIME;
            end
            S_PRIME: begin
                load       = 1'b1;
                O_SA_START = 1'b1;
                if (k_len > K_W'(1)) begin
                    O_RD_EN  = 1'b1;
                    O_RD_IDX = K_W'(1);
                end
                state_nx = S_FEED;
            end
            S_FEED: if (I_SA_SHIFT) begin
                load = 1'b1;
                if (k_cnt + CNT_W'(1) < k_len_ext) begin
                    O_RD_EN  = 1'b1;
                    O_RD_IDX = K_W'(k_cnt + CNT_W'(1));
                end
                if (step_cnt + CNT_W'(1) == k_len_ext + DRAIN) state_nx = S_DONE;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Past the last operand the heads take zeros so the chains drain cleanly.
    assign head_en = (k_cnt < k_len_ext);

    assign O_BUSY         = (state != S_IDLE);
    assign O_DONE         = (state == S_DONE);
    assign O_SA_SYNC_RSTN = (state != S_CLR);
    assign O_DBG_STATE    = state;

    sa_skew #(.LANES(SA_R), .D_W(D_W)) u_skew_x (
        .I_CLK      (I_CLK),
        .I_ASYN_RST (I_ASYN_RST),
        .I_LOAD     (load),
        .I_CLEAR    (clear),
        .I_HEAD     (head_en ? I_X_VEC : '0),
        .O_TAIL     (O_SA_X)
    );

    sa_skew #(.LANES(SA_C), .D_W(D_W)) u_skew_w (
        .I_CLK      (I_CLK),
        .I_ASYN_RST (I_ASYN_RST),
        .I_LOAD     (load),
        .I_CLEAR    (clear),
        .I_HEAD     (head_en ? I_W_VEC : '0),
        .O_TAIL     (O_SA_W)
    );

endmodule

// File: tb/tb_sa_ctrl.sv
// Self-checking bench for sa_ctrl: job table plus random jobs against a timing/skew model
// and a behavioural systolic-array accumulation compared to the direct matrix product.
module tb_sa_ctrl;
    import sa_pkg::*;

    localparam int D_W   = 16;
    localparam int SA_R  = 16;
    localparam int SA_C  = 16;
    localparam int K_W   = 10;
    localparam int DRAIN = SA_R + SA_C - 2;
    localparam int HMAX  = 128;

    logic                I_CLK;
    logic                I_ASYN_RST;
    logic                I_START;
    logic [K_W-1:0]      I_K_LEN;
    logic                O_BUSY;
    logic                O_DONE;
    logic                O_RD_EN;
    logic [K_W-1:0]      O_RD_IDX;
    logic [D_W*SA_R-1:0] I_X_VEC;
    logic [D_W*SA_C-1:0] I_W_VEC;
    logic                O_SA_START;
    logic                O_SA_SYNC_RSTN;
    logic [D_W*SA_R-1:0] O_SA_X;
    logic [D_W*SA_C-1:0] O_SA_W;
    logic                I_SA_SHIFT;
    logic [2:0]          O_DBG_STATE;

    sa_ctrl dut (
        .I_CLK          (I_CLK),
        .I_ASYN_RST     (I_ASYN_RST),
        .I_START        (I_START),
        .I_K_LEN        (I_K_LEN),
        .O_BUSY         (O_BUSY),
        .O_DONE         (O_DONE),
        .O_RD_EN        (O_RD_EN),
        .O_RD_IDX       (O_RD_IDX),
        .I_X_VEC        (I_X_VEC),
        .I_W_VEC        (I_W_VEC),
        .O_SA_START     (O_SA_START),
        .O_SA_SYNC_RSTN (O_SA_SYNC_RSTN),
        .O_SA_X         (O_SA_X),
        .O_SA_W         (O_SA_W),
        .I_SA_SHIFT     (I_SA_SHIFT),
        .O_DBG_STATE    (O_DBG_STATE)
    );

    // ---------------- clock / reset
    initial I_CLK = 1'b0;
    always #5 I_CLK = ~I_CLK;

    // ---------------- operand buffers: X[i][k], W[k][j]
    logic [D_W-1:0] mx [0:SA_R-1][0:31];
    logic [D_W-1:0] mw [0:31][0:SA_C-1];
    logic           rd_pend;
    logic [K_W-1:0] rd_pend_idx;

    always @(negedge I_CLK) begin
        rd_pend     = O_RD_EN;
        rd_pend_idx = O_RD_IDX;
    end

    always @(posedge I_CLK) begin
        #1;
        if (rd_pend && int'(rd_pend_idx) < 32) begin
            for (int i = 0; i < SA_R; i++) I_X_VEC[i*D_W +: D_W] = mx[i][int'(rd_pend_idx)];
            for (int j = 0; j < SA_C; j++) I_W_VEC[j*D_W +: D_W] = mw[int'(rd_pend_idx)][j];
        end
    end

    // ---------------- scoreboard state
    int             n_checks = 0;
    int             n_errors = 0;
    logic [K_W-1:0] exp_q[$];
    int             hx [0:HMAX-1][0:SA_R-1];
    int             hw [0:HMAX-1][0:SA_C-1];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int k_len;
        int xmode;       // 0 random, 1 identity X / ramp W, 2 X[i][k]=i*16+k
        int gap;         // shift period in cycles, 0 = random 2..6
        int start_step;  // step at which a stray I_START is pulsed, -1 none
        int rst_step;    // step at which reset is asserted, -1 none
        int exp_reads;
        int exp_dones;
    } job_t;

    function automatic logic [D_W-1:0] rnd_val();
        return D_W'(int'($urandom_range(0, 200)) - 100);
    endfunction

    task automatic fill_operands(input int xmode);
        for (int i = 0; i < SA_R; i++)
            for (int k = 0; k < 32; k++)
                case (xmode)
                    1:       mx[i][k] = (i == k) ? 16'h2000 : 16'h0000;
                    2:       mx[i][k] = D_W'(i * 16 + k);
                    default: mx[i][k] = rnd_val();
                endcase
        for (int k = 0; k < 32; k++)
            for (int j = 0; j < SA_C; j++)
                mw[k][j] = (xmode == 1) ? D_W'(k * 16 + j) : rnd_val();
    endtask

    // After n loads, lane i's tail holds element n-1-i (zero outside 0..K-1).
    function automatic logic [D_W*SA_R-1:0] exp_tail_x(input int n, input int kl);
        logic [D_W*SA_R-1:0] v;
        v = '0;
        for (int i = 0; i < SA_R; i++)
            if (n - 1 - i >= 0 && n - 1 - i < kl) v[i*D_W +: D_W] = mx[i][n-1-i];
        return v;
    endfunction

    function automatic logic [D_W*SA_C-1:0] exp_tail_w(input int n, input int kl);
        logic [D_W*SA_C-1:0] v;
        v = '0;
        for (int j = 0; j < SA_C; j++)
            if (n - 1 - j >= 0 && n - 1 - j < kl) v[j*D_W +: D_W] = mw[n-1-j][j];
        return v;
    endfunction

    // PE(i,j) sees the row-i edge value delayed j steps and the column-j value delayed i steps.
    task automatic check_array(input int kl);
        int bad, bi, bj, bgot, bref, acc, refv, a, b;
        bad = 0; bi = 0; bj = 0; bgot = 0; bref = 0;
        for (int i = 0; i < SA_R; i++)
            for (int j = 0; j < SA_C; j++) begin
                refv = 0;
                for (int k = 0; k < kl; k++) begin
                    a = int'($signed(mx[i][k]));
                    b = int'($signed(mw[k][j]));
                    refv += a * b;
                end
                acc = 0;
                for (int n = 1; n < HMAX; n++)
                    if (n - j >= 1 && n - i >= 1) acc += hx[n-j][i] * hw[n-i][j];
                if (acc != refv) begin
                    if (bad == 0) begin bi = i; bj = j; bgot = acc; bref = refv; end
                    bad++;
                end
            end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL array_result: %0d PEs wrong, PE(%0d,%0d) got %0d expected %0d", bad, bi, bj, bgot, bref);
        end
    endtask

    // ---------------- driver + model for one job
    task automatic run_job(input job_t jb);
        int phase = 0, steps = 0, loads = 0, gap_left = 0;
        int n_reads = 0, n_dones = 0, linger = -1;
        bit p_start = 0, p_shift = 0, p_rst = 0, mid_sent = 0, rst_sent = 0;
        bit finished = 0, loaded, exp_en;
        logic [K_W-1:0] p_k = '0, exp_idx, got_idx;
        fill_operands(jb.xmode);
        for (int n = 0; n < HMAX; n++) begin
            for (int i = 0; i < SA_R; i++) hx[n][i] = 0;
            for (int j = 0; j < SA_C; j++) hw[n][j] = 0;
        end
        exp_q.delete();
        if (jb.k_len == 0) linger = 12;

        for (int c = 0; c < 2000 && !finished; c++) begin
            @(posedge I_CLK); #1;
            loaded = 0;
            if (p_rst) begin
                I_ASYN_RST = 1'b0;
                p_rst      = 0;
                linger     = 30;
            end else begin
                case (phase)
                    0: if (p_start && p_k != '0) phase = 1;
                    1: phase = 2;
                    2: begin phase = 3; loads = 1; loaded = 1; end
                    3: if (p_shift) begin
                        steps++; loads++; loaded = 1;
                        if (steps == jb.k_len + DRAIN) phase = 4;
                    end
                    4: begin phase = 0; linger = 4; end
                    default: phase = 0;
                endcase
            end

            I_START = (c == 0) || (phase == 3 && steps == jb.start_step && !mid_sent);
            if (phase == 3 && steps == jb.start_step) mid_sent = 1;
            I_K_LEN = (c == 0) ? K_W'(jb.k_len) : K_W'($urandom_range(1, 20));
            if (gap_left == 0) begin
                I_SA_SHIFT = 1'b1;
                gap_left   = (jb.gap > 0) ? jb.gap - 1 : int'($urandom_range(1, 5));
            end else begin
                I_SA_SHIFT = 1'b0;
                gap_left--;
            end
            if (phase == 3 && steps == jb.rst_step && !rst_sent) begin
                I_ASYN_RST = 1'b1;
                rst_sent   = 1;
                p_rst      = 1;
                phase      = 0;
                loads      = 0;
                loaded     = 0;
            end

            @(negedge I_CLK);
            exp_en  = 0;
            exp_idx = '0;
            case (phase)
                1: exp_en = 1;
                2: begin exp_en = (jb.k_len > 1); exp_idx = K_W'(1); end
                3: begin exp_en = I_SA_SHIFT && (steps + 2 < jb.k_len); exp_idx = K_W'(steps + 2); end
                default: ;
            endcase
            if (exp_en) exp_q.push_back(exp_idx);

            check("ctrl{busy,done,rstn,start,rd_en}",
                  {O_BUSY, O_DONE, O_SA_SYNC_RSTN, O_SA_START, O_RD_EN},
                  {phase != 0, phase == 4, phase != 1, phase == 2, exp_en});
            if (O_RD_EN) begin
                n_reads++;
                got_idx = O_RD_IDX;
                if (exp_q.size() == 0) check("rd_unexpected", got_idx, ~got_idx);
                else check("rd_idx", got_idx, exp_q.pop_front());
            end
            if (O_DONE) n_dones++;
            check("sa_x_tail", O_SA_X, exp_tail_x(loads, jb.k_len));
            check("sa_w_tail", O_SA_W, exp_tail_w(loads, jb.k_len));
            if (loaded && loads < HMAX) begin
                for (int i = 0; i < SA_R; i++) hx[loads][i] = int'($signed(O_SA_X[i*D_W +: D_W]));
                for (int j = 0; j < SA_C; j++) hw[loads][j] = int'($signed(O_SA_W[j*D_W +: D_W]));
            end

            p_start = I_START;
            p_k     = I_K_LEN;
            p_shift = I_SA_SHIFT;
            if (linger > 0) begin
                linger--;
                if (linger == 0) finished = 1;
            end
        end

        I_START    = 1'b0;
        I_SA_SHIFT = 1'b0;
        check("job_timeout", finished, 1'b1);
        check("read_count", n_reads, jb.exp_reads);
        check("done_count", n_dones, jb.exp_dones);
        check("reads_left", exp_q.size(), 0);
        if (jb.exp_dones == 1) check_array(jb.k_len);
    endtask

    // ---------------- test sequence
    job_t jobs [7];

    initial begin
        jobs[0] = '{k_len: 8, xmode: 0, gap: 5, start_step: -1, rst_step: 3,  exp_reads: 5, exp_dones: 0};
        jobs[1] = '{k_len: 4, xmode: 1, gap: 5, start_step: -1, rst_step: -1, exp_reads: 4, exp_dones: 1};
        jobs[2] = '{k_len: 2, xmode: 2, gap: 5, start_step: -1, rst_step: -1, exp_reads: 2, exp_dones: 1};
        jobs[3] = '{k_len: 0, xmode: 0, gap: 3, start_step: -1, rst_step: -1, exp_reads: 0, exp_dones: 0};
        jobs[4] = '{k_len: 3, xmode: 0, gap: 5, start_step: 2,  rst_step: -1, exp_reads: 3, exp_dones: 1};
        jobs[5] = '{k_len: 1, xmode: 0, gap: 4, start_step: -1, rst_step: -1, exp_reads: 1, exp_dones: 1};
        jobs[6] = '{k_len: 5, xmode: 2, gap: 2, start_step: -1, rst_step: -1, exp_reads: 5, exp_dones: 1};

        I_ASYN_RST = 1'b1;
        I_START    = 1'b0;
        I_K_LEN    = '0;
        I_SA_SHIFT = 1'b0;
        I_X_VEC    = '0;
        I_W_VEC    = '0;
        rd_pend    = 1'b0;
        rd_pend_idx = '0;
        repeat (3) @(posedge I_CLK);
        @(negedge I_CLK);
        check("reset_ctrl{busy,done,rstn,start,rd_en}",
              {O_BUSY, O_DONE, O_SA_SYNC_RSTN, O_SA_START, O_RD_EN}, 5'b00100);
        check("reset_rd_idx", O_RD_IDX, 0);
        check("reset_sa_x", O_SA_X, 0);
        check("reset_sa_w", O_SA_W, 0);
        check("reset_state", O_DBG_STATE, S_IDLE);
        @(posedge I_CLK); #1;
        I_ASYN_RST = 1'b0;

        for (int t = 0; t < 7; t++) run_job(jobs[t]);

        for (int r = 0; r < 6; r++) begin
            job_t jr;
            jr.k_len      = int'($urandom_range(1, 20));
            jr.xmode      = 0;
            jr.gap        = 0;
            jr.start_step = -1;
            jr.rst_step   = -1;
            jr.exp_reads  = jr.k_len;
            jr.exp_dones  = 1;
            run_job(jr);
        end

        // Shift held high in S_IDLE must not wake the sequencer or issue reads.
        for (int c = 0; c < 6; c++) begin
            @(posedge I_CLK); #1;
            I_SA_SHIFT = 1'b1;
            @(negedge I_CLK);
            check("idle_shift_busy_rd", {O_BUSY, O_RD_EN, O_SA_START}, 3'b000);
            check("idle_shift_state", O_DBG_STATE, S_IDLE);
        end
        I_SA_SHIFT = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sa_ctrl.md
Name: sa_ctrl

Overview:
Sequencer for the 16x16 output-stationary systolic array. It accepts one matrix-multiply job of inner dimension K and fetches the X rows and W columns from the operand buffers by index. It presents them to the array with diagonal skew and paces every advance on the array's PE-shift pulse. It drains the array and signals completion while the array holds its results.

Parameters:
D_W, 16, operand width (Q2.13 signed fixed point)
SA_R, 16, array rows
SA_C, 16, array columns
K_W, 10, width of K length and buffer read index

Ports:
I_CLK  in  1  clock
I_ASYN_RST  in  1  asynchronous active-high reset
I_START  in  1  job request pulse; sampled only in S_IDLE
I_K_LEN  in  K_W  inner dimension K; sampled with I_START
O_BUSY  out  1  high from job acceptance until O_DONE
O_DONE  out  1  one-cycle completion pulse
O_RD_EN  out  1  operand buffer read strobe
O_RD_IDX  out  K_W  index k of the X column / W row being fetched
I_X_VEC  in  D_W x SA_R  X[0..SA_R-1][k]; valid the cycle after O_RD_EN and held until the next read
I_W_VEC  in  D_W x SA_C  W[k][0..SA_C-1]; same timing as I_X_VEC
O_SA_START  out  1  array start flag, one-cycle pulse
O_SA_SYNC_RSTN  out  1  array synchronous reset, active low
O_SA_X  out  D_W x SA_R  skewed left-edge inputs to the array
O_SA_W  out  D_W x SA_C  skewed top-edge inputs to the array
I_SA_SHIFT  in  1  array PE-shift pulse; one step per high cycle

Behaviour:
- Reset (async, active-high):
  - state S_IDLE; all skew registers 0; step and k counters 0.
  - O_BUSY=0, O_DONE=0, O_RD_EN=0, O_RD_IDX=0, O_SA_START=0, O_SA_SYNC_RSTN=1.
  - A reset mid-job aborts the job immediately; no O_DONE is produced.
- Step: a cycle with I_SA_SHIFT=1 while in S_FEED. Steps are at least 2 cycles apart (the array updates every 5 clk).
- Skew chain:
  - Row i is a shift chain of depth i+1. O_SA_X[i] is the chain tail.
  - Column j is likewise a chain of depth j+1 for O_SA_W[j].
  - All chains advance together on a load event. The chain head takes I_X_VEC[i] / I_W_VEC[j] while k<K, otherwise 0.
- State machine:
  - S_IDLE:
    - I_START=1 and I_K_LEN!=0: latch K, assert O_BUSY, go S_CLR.
    - I_K_LEN==0: request ignored, stay in S_IDLE.
  - S_CLR (1 cycle): O_SA_SYNC_RSTN=0, skew registers cleared, O_RD_EN=1, O_RD_IDX=0. Go S_PRIME.
  - S_PRIME (1 cycle):
    - Load event with vector k=0, so the heads hold element 0.
    - O_SA_START=1.
    - If K>1: O_RD_EN=1, O_RD_IDX=1.
    - k<=1. Go S_FEED.
  - S_FEED: on each step:
    - Load event (fetched vector if k<K, else zeros); k<=k+1; step count +1.
    - If k+1<K: issue read of k+1.
    - When the step count reaches K+SA_R+SA_C-2, go S_DONE on the same edge.
  - S_DONE (1 cycle): O_DONE=1, O_BUSY<=0. Go S_IDLE.
- Hold behaviour:
  - I_SA_SHIFT outside S_FEED has no effect.
  - I_START while busy is ignored and not queued.
  - In S_IDLE the skew registers are zero, so the array, which keeps shifting, accumulates zeros and its results are preserved.
  - O_SA_SYNC_RSTN is low only in S_CLR.
- Reads:
  - At most one O_RD_EN per step.
  - O_RD_IDX never reaches K.
  - The read for index k+1 completes before the next step.
- No arithmetic beyond counters. Step counter width is K_W+6, with no wrap for legal K.

Decomposition:
- Package sa_pkg:
  - state enum (S_IDLE, S_CLR, S_PRIME, S_FEED, S_DONE);
  - default D_W/SA_R/SA_C;
  - drain-length constant SA_R+SA_C-2.
- One sub-module, sa_skew:
  - parameterised by lane count and D_W;
  - ports load, clear, head vector, tail vector;
  - instantiated once for X (SA_R lanes) and once for W (SA_C lanes).

Test Plan:
- Reset mid-S_FEED (K=8, after 3 steps) -> next cycle all outputs at reset values, O_DONE never pulses, O_SA_X/O_SA_W all 0.
- K=4, I_SA_SHIFT every 5 clk, identity X / ramp W -> O_RD_IDX sequence 0,1,2,3. O_DONE exactly at step 4+30=34, one cycle wide, O_BUSY low after. A reference array model's outputs equal X*W.
- Skew check, K=2, X[i][k]=i*16+k -> O_SA_X[5] shows 0 for 5 steps after prime, then 0x0050, 0x0051, then 0.
- I_START with I_K_LEN=0 -> O_BUSY stays 0, no read, no O_SA_START.
- I_START pulsed during S_FEED with K=3 -> ignored. A single O_DONE at step 33. A new start after O_DONE is accepted and O_SA_SYNC_RSTN pulses low for 1 cycle.
- I_SA_SHIFT pulses in S_IDLE / S_DONE -> no counter change and no read.
